// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//  - Read-owner encodings: OWN_NONE (no read in flight), OWN_PROC (processor),
//    OWN_PER + i (peripheral i).
//  - Width helpers for the owner register, the aging counter and the
//    round-robin index.
package dmem_arbiter_pkg;

    localparam int OWN_NONE = 0;
    localparam int OWN_PROC = 1;
    localparam int OWN_PER  = 2;

    // Owner register must hold OWN_PER + (n_req - 1).
    function automatic int owner_width(input int n_req);
        return $clog2(n_req + OWN_PER);
    endfunction

    // Aging counter saturates at max_wait.
    function automatic int wait_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

    // Requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_picker.sv
// Round-robin picker: combinational search of the request vector starting at
// rr_ptr and wrapping upward. Produces a one-hot grant and its index; both are
// zero when no request is present.
//  req     in   N_REQ   request vector
//  rr_ptr  in   IDX_W   highest-priority requester this cycle (< N_REQ)
//  gnt     out  N_REQ   one-hot pick
//  idx     out  IDX_W   index of the pick
module rr_picker
    import dmem_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port synchronous data RAM between the processor M stage
// and N_REQ peripheral masters. The processor has priority; an aging counter
// forces a peripheral grant after MAX_WAIT denied cycles. Grants and mem_* are
// combinational from state and requests; read data returns one cycle later.
//  clock, reset                 clock; asynchronous active-low reset
//  proc_req/we/addr/wdata       processor access; proc_stall when not served
//  proc_rdata                   load data (qualified by the processor's own timing)
//  per_req/we/addr/wdata        packed peripheral requests, i at [i*W +: W]
//  per_gnt, per_rvalid          one-hot grant (same cycle), read valid (next cycle)
//  per_rdata                    shared peripheral read bus
//  mem_addr/we/wdata, mem_rdata single-port RAM interface, 1-cycle read latency
//
// Peripheral handshake: per_req[i] acts as valid and per_gnt[i] as ready; the
// access (addr/we/wdata) is transferred in the cycle both are high. A requester
// keeps per_req high until granted, but may withdraw it without a transfer.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int N_REQ    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      proc_req,
    input  logic                      proc_we,
    input  logic [ADDR_W-1:0]         proc_addr,
    input  logic [DATA_W-1:0]         proc_wdata,
    output logic                      proc_stall,
    output logic [DATA_W-1:0]         proc_rdata,
    input  logic [N_REQ-1:0]          per_req,
    input  logic [N_REQ-1:0]          per_we,
    input  logic [N_REQ*ADDR_W-1:0]   per_addr,
    input  logic [N_REQ*DATA_W-1:0]   per_wdata,
    output logic [N_REQ-1:0]          per_gnt,
    output logic [N_REQ-1:0]          per_rvalid,
    output logic [DATA_W-1:0]         per_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W  = idx_width(N_REQ);
    localparam int WAIT_W = wait_width(MAX_WAIT);
    localparam int OWN_W  = owner_width(N_REQ);

    logic [IDX_W-1:0]  rr_ptr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [OWN_W-1:0]  rd_owner;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              any_per;
    logic              force_per;
    logic              per_win;
    logic              proc_win;
    logic              win_we;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (per_req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    // Winner selection is left ungated so the state flops never see reset
    // through their data path; only the visible outputs are gated below.
    always_comb begin
        any_per   = |per_req;
        force_per = any_per && (wait_cnt == WAIT_W'(MAX_WAIT));
        per_win   = any_per && (force_per || !proc_req);
        proc_win  = proc_req && !per_win;
        win_we    = per_win ? per_we[pick_idx] : (proc_win && proc_we);
    end

    always_comb begin
        per_gnt    = reset && per_win ? pick_gnt : '0;
        proc_stall = reset && proc_req && !proc_win;
        mem_we     = reset && win_we;
        mem_addr   = per_win ? per_addr[pick_idx*ADDR_W +: ADDR_W] : proc_addr;
        mem_wdata  = per_win ? per_wdata[pick_idx*DATA_W +: DATA_W] : proc_wdata;
        proc_rdata = mem_rdata;
        per_rdata  = mem_rdata;
        for (int i = 0; i < N_REQ; i++) begin
            per_rvalid[i] = (rd_owner == OWN_W'(OWN_PER + i));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            wait_cnt <= '0;
            rd_owner <= OWN_W'(OWN_NONE);
        end else begin
            if (per_win) begin
                rr_ptr <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            end

            if (!any_per || per_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // Writes produce no response, so only a read records an owner.
            if (per_win && !win_we) begin
                rd_owner <= OWN_W'(OWN_PER) + OWN_W'(pick_idx);
            end else if (proc_win && !win_we) begin
                rd_owner <= OWN_W'(OWN_PROC);
            end else begin
                rd_owner <= OWN_W'(OWN_NONE);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int N_REQ    = 2;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    proc_req, proc_we;
    logic [ADDR_W-1:0]       proc_addr;
    logic [DATA_W-1:0]       proc_wdata;
    logic                    proc_stall;
    logic [DATA_W-1:0]       proc_rdata;
    logic [N_REQ-1:0]        per_req, per_we;
    logic [N_REQ*ADDR_W-1:0] per_addr;
    logic [N_REQ*DATA_W-1:0] per_wdata;
    logic [N_REQ-1:0]        per_gnt, per_rvalid;
    logic [DATA_W-1:0]       per_rdata;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
        .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / RAM ----------------
    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        return DATA_W'(32'h9E3779B9 * a) ^ DATA_W'(a);
    endfunction

    logic [DATA_W-1:0] ram [DEPTH];
    logic              ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: arbitration rules, aging count, rotating priority and a
    // shadow memory. Pending read responses sit in exp_q (data) / own_q (owner,
    // -1 = processor); at most one entry is outstanding at a time.
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                own_q [$];
    int                m_wait, m_rr;
    logic [N_REQ-1:0]  obs_gnt;
    logic              obs_stall;

    task automatic cycle_check();
        int                g;
        bit                any, per_wins, we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic [N_REQ-1:0]  exp_rv;
        @(negedge clock);
        obs_gnt   = per_gnt;
        obs_stall = proc_stall;
        if (!reset) begin
            chk("rst_gnt", 64'(per_gnt), 0);
            chk("rst_stall", 64'(proc_stall), 0);
            chk("rst_we", 64'(mem_we), 0);
            chk("rst_rvalid", 64'(per_rvalid), 0);
            m_wait = 0;
            m_rr   = 0;
            exp_q.delete();
            own_q.delete();
        end else begin
            exp_rv = '0;
            if (exp_q.size() > 0) begin
                if (own_q[0] < 0) chk("proc_rdata", 64'(proc_rdata), 64'(exp_q[0]));
                else begin
                    exp_rv[own_q[0]] = 1'b1;
                    chk("per_rdata", 64'(per_rdata), 64'(exp_q[0]));
                end
                void'(exp_q.pop_front());
                void'(own_q.pop_front());
            end
            chk("rvalid", 64'(per_rvalid), 64'(exp_rv));

            any      = (per_req != 0);
            per_wins = any && (m_wait == MAX_WAIT || !proc_req);
            g = -1;
            if (per_wins)
                for (int k = 0; k < N_REQ; k++)
                    if (g < 0 && per_req[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;

            chk("gnt", 64'(per_gnt), per_wins ? (64'd1 << g) : 64'd0);
            chk("stall", 64'(proc_stall), 64'(proc_req && per_wins));

            if (per_wins) begin
                a  = per_addr[g*ADDR_W +: ADDR_W];
                we = per_we[g];
                wd = per_wdata[g*DATA_W +: DATA_W];
            end else begin
                a  = proc_addr;
                we = proc_req && proc_we;
                wd = proc_wdata;
            end
            chk("mem_addr", 64'(mem_addr), 64'(a));
            chk("mem_we", 64'(mem_we), 64'(we));
            if (we) chk("mem_wdata", 64'(mem_wdata), 64'(wd));

            if ((per_wins || proc_req) && !we) begin
                exp_q.push_back(shadow[a]);
                own_q.push_back(per_wins ? g : -1);
            end
            if (we) shadow[a] = wd;

            if (per_wins) m_rr = (g + 1) % N_REQ;
            if (!any || per_wins) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_proc(input bit req, input bit we, input int addr, input logic [DATA_W-1:0] wd);
        proc_req   = req;
        proc_we    = we;
        proc_addr  = ADDR_W'(addr);
        proc_wdata = wd;
    endtask

    task automatic drive_per(input int i, input bit req, input bit we, input int addr, input logic [DATA_W-1:0] wd);
        per_req[i] = req;
        per_we[i]  = we;
        per_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'(addr);
        per_wdata[i*DATA_W +: DATA_W] = wd;
    endtask

    task automatic all_idle();
        drive_proc(0, 0, 0, '0);
        for (int i = 0; i < N_REQ; i++) drive_per(i, 0, 0, 0, '0);
    endtask

    // Holds proc and peripheral 0 requests until peripheral 0 is granted and
    // returns the cycle number (1-based) of that grant, 0 if none in 8 cycles.
    task automatic starve_run(output int first);
        first = 0;
        drive_proc(1, 0, 'h020, '0);
        drive_per(0, 1, 0, 'h030, '0);
        for (int c = 1; c <= 8 && first == 0; c++) begin
            cycle_check();
            if (obs_gnt[0]) begin
                first = c;
                drive_per(0, 0, 0, 0, '0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        m_wait = 0;
        m_rr   = 0;
        reset  = 1'b0;
        all_idle();
        @(posedge clock);
        #1;

        // Reset held with every request high: all grant outputs gated.
        drive_proc(1, 1, 'h005, 32'h1111_2222);
        for (int i = 0; i < N_REQ; i++) drive_per(i, 1, 1, 'h006 + i, 32'hAAAA_0000 + i);
        repeat (3) cycle_check();
        reset = 1'b1;
        drive_proc(1, 0, 'h005, '0);
        cycle_check();
        chk("release_proc_first", 64'(obs_stall), 0);
        all_idle();
        cycle_check();

        // Processor only: load, store, load-back.
        drive_proc(1, 0, 'h010, '0);           cycle_check();
        drive_proc(1, 1, 'h011, 32'hDEADBEEF); cycle_check();
        drive_proc(1, 0, 'h011, '0);           cycle_check();
        all_idle();                            cycle_check();

        // Starvation bound: processor served MAX_WAIT cycles, then forced grant.
        starve_run(first);
        chk("starve_cycle", 64'(first), 64'(MAX_WAIT + 1));
        all_idle();
        cycle_check();

        // Round-robin between two reading peripherals, processor idle.
        drive_per(0, 1, 0, 'h040, '0);
        drive_per(1, 1, 0, 'h041, '0);
        repeat (6) cycle_check();
        all_idle();
        cycle_check();

        // Reset while a peripheral read is in flight.
        drive_per(1, 1, 0, 'h050, '0);
        cycle_check();
        reset = 1'b0;
        all_idle();
        cycle_check();
        reset = 1'b1;
        cycle_check();
        drive_per(0, 1, 0, 'h060, '0);
        drive_per(1, 1, 0, 'h061, '0);
        cycle_check();
        chk("rr_after_reset", 64'(obs_gnt), 64'd1);
        all_idle();
        cycle_check();

        // Withdrawn request under processor traffic: no grant, aging cleared.
        drive_proc(1, 0, 'h070, '0);
        drive_per(1, 1, 0, 'h071, '0);
        repeat (2) cycle_check();
        drive_per(1, 0, 0, 0, '0);
        repeat (3) begin
            cycle_check();
            chk("withdraw_nostall", 64'(obs_stall), 0);
        end
        starve_run(first);
        chk("withdraw_wait_cleared", 64'(first), 64'(MAX_WAIT + 1));
        all_idle();
        cycle_check();

        // Randomized traffic; peripherals mostly hold requests until granted.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            drive_proc($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 31), $urandom);
            for (int i = 0; i < N_REQ; i++) begin
                if (per_req[i] && !obs_gnt[i]) begin
                    if ($urandom_range(0, 15) == 0) drive_per(i, 0, 0, 0, '0);
                end else if ($urandom_range(0, 2) == 0) begin
                    drive_per(i, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom);
                end else begin
                    drive_per(i, 0, 0, 0, '0);
                end
            end
            cycle_check();
        end
        reset = 1'b1;
        all_idle();
        repeat (2) cycle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
